// File: rtl/text_console_writer.sv
// Write side of the VGA text character RAM: turns a byte stream into cell writes,
// tracks the text cursor and handles CR/LF/BS/FF plus line and screen clears.
module text_console_writer #(
    parameter int COLS   = 20,
    parameter int ROWS   = 15,
    parameter int ADDR_W = 9
) (
    input  logic              px_clk,
    input  logic              rstn,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              write_en,
    output logic [4:0]        cursor_x,
    output logic [3:0]        cursor_y,
    output logic              busy
);

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CELLS    = (ADDR_W+1)'(COLS * ROWS);
    localparam logic [ADDR_W:0] LINE     = (ADDR_W+1)'(COLS);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [4:0]      LAST_COL = 5'(COLS - 1);
    localparam logic [3:0]      LAST_ROW = 4'(ROWS - 1);
    localparam logic [7:0]      SPACE    = 8'h20;

    state_t            state, state_d;
    logic [ADDR_W:0]   cnt, cnt_d;
    logic [4:0]        col, col_d;
    logic [3:0]        row, row_d;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [7:0]        wdata_d;
    logic [3:0]        row_adv;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] r, input logic [4:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] r);
        return (r == LAST_ROW) ? 4'd0 : r + 4'd1;
    endfunction

    assign din_ready = (state == IDLE);
    assign busy      = ~din_ready;
    assign cursor_x  = col;
    assign cursor_y  = row;
    assign row_adv   = next_row(row);

    // Clear states issue one write per count and spend one extra count returning to IDLE,
    // so din_ready rises only after the last clear write has left the outputs.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        col_d   = col;
        row_d   = row;
        we_d    = 1'b0;
        waddr_d = waddr;
        wdata_d = wdata;
        case (state)
            CLR_ALL: begin
                if (cnt == CELLS) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = cnt[ADDR_W-1:0];
                    wdata_d = SPACE;
                    cnt_d   = cnt + CNT_ONE;
                end
            end
            CLR_LINE: begin
                if (cnt == LINE) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = cell_addr(row, cnt[4:0]);
                    wdata_d = SPACE;
                    cnt_d   = cnt + CNT_ONE;
                end
            end
            IDLE: begin
                if (din_valid) begin
                    if (din >= 8'h20 && din <= 8'h7E) begin
                        we_d    = 1'b1;
                        waddr_d = cell_addr(row, col);
                        wdata_d = din;
                        if (col == LAST_COL) begin
                            col_d   = 5'd0;
                            row_d   = row_adv;
                            cnt_d   = '0;
                            state_d = CLR_LINE;
                        end else begin
                            col_d = col + 5'd1;
                        end
                    end else if (din == 8'h0A) begin
                        // First cell of the new line is written straight from IDLE.
                        col_d   = 5'd0;
                        row_d   = row_adv;
                        we_d    = 1'b1;
                        waddr_d = cell_addr(row_adv, 5'd0);
                        wdata_d = SPACE;
                        cnt_d   = CNT_ONE;
                        state_d = CLR_LINE;
                    end else if (din == 8'h0D) begin
                        col_d = 5'd0;
                    end else if (din == 8'h08) begin
                        if (col != 5'd0) begin
                            col_d   = col - 5'd1;
                            we_d    = 1'b1;
                            waddr_d = cell_addr(row, col - 5'd1);
                            wdata_d = SPACE;
                        end
                    end else if (din == 8'h0C) begin
                        col_d   = 5'd0;
                        row_d   = 4'd0;
                        we_d    = 1'b1;
                        waddr_d = '0;
                        wdata_d = SPACE;
                        cnt_d   = CNT_ONE;
                        state_d = CLR_ALL;
                    end
                end
            end
            default: state_d = CLR_ALL;
        endcase
    end

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= CLR_ALL;
            cnt      <= '0;
            col      <= 5'd0;
            row      <= 4'd0;
            write_en <= 1'b0;
            waddr    <= '0;
            wdata    <= 8'h00;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            col      <= col_d;
            row      <= row_d;
            write_en <= we_d;
            waddr    <= waddr_d;
            wdata    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: clears, printing, wrap, control codes, reset abort.
module tb_text_console_writer;

    logic       px_clk = 1'b0;
    logic       rstn;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [8:0] waddr;
    logic [7:0] wdata;
    logic       write_en;
    logic [4:0] cursor_x;
    logic [3:0] cursor_y;
    logic       busy;

    int tests = 0;
    int fails = 0;

    text_console_writer #(.COLS(20), .ROWS(15), .ADDR_W(9)) dut (
        .px_clk    (px_clk),
        .rstn      (rstn),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .waddr     (waddr),
        .wdata     (wdata),
        .write_en  (write_en),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    always #5 px_clk = ~px_clk;

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected write {write_en, waddr, wdata}
    function automatic logic [31:0] wr(input int a, input logic [7:0] d);
        return {14'd0, 1'b1, 9'(a), d};
    endfunction

    function automatic logic [31:0] obs();
        return {14'd0, write_en, waddr, wdata};
    endfunction

    task automatic send(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!din_ready && n < 100) begin
            tick();
            n++;
        end
        chk("drain_ready", {31'd0, din_ready}, 32'd1);
    endtask

    task automatic full_clear();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("clr_all_write", obs(), wr(i, 8'h20));
            chk("clr_all_busy", {31'd0, din_ready}, 32'd0);
        end
        tick();
        chk("clr_all_done_ready", {31'd0, din_ready}, 32'd1);
        chk("clr_all_done_we", {31'd0, write_en}, 32'd0);
        chk("clr_all_cursor", {23'd0, cursor_x, cursor_y}, 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        tick();
        tick();
        chk("rst_outputs", {14'd0, write_en, waddr, wdata}, 32'd0);
        chk("rst_ready", {30'd0, din_ready, busy}, 32'd1);
        chk("rst_cursor", {23'd0, cursor_x, cursor_y}, 32'd0);

        // Power-up clear
        rstn = 1'b1;
        full_clear();

        // Back-to-back printable bytes
        din = 8'h48; din_valid = 1'b1;
        tick();
        chk("H_write", obs(), wr(0, 8'h48));
        chk("H_cursor", {27'd0, cursor_x}, 32'd1);
        din = 8'h69;
        tick();
        din_valid = 1'b0;
        chk("i_write", obs(), wr(1, 8'h69));
        chk("i_cursor", {27'd0, cursor_x}, 32'd2);

        // CR: column home, no write
        send(8'h0D);
        chk("cr_no_write", {31'd0, write_en}, 32'd0);
        chk("cr_cursor", {23'd0, cursor_x, cursor_y}, 32'd0);

        // Twenty 'A' fill row 0 then wrap into a clear of row 1
        din = 8'h41; din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("A_write", obs(), wr(i, 8'h41));
        end
        din_valid = 1'b0;
        chk("wrap_cursor", {23'd0, cursor_x, cursor_y}, {23'd0, 5'd0, 4'd1});
        chk("wrap_busy_n1", {31'd0, din_ready}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("wrap_clear", obs(), wr(20 + k, 8'h20));
            chk("wrap_busy", {31'd0, din_ready}, 32'd0);
        end
        tick();
        chk("wrap_ready", {31'd0, din_ready}, 32'd1);
        chk("wrap_idle_we", {31'd0, write_en}, 32'd0);

        // LF from row 1: clear of row 2 begins at N+1
        send(8'h0A);
        chk("lf_first", obs(), wr(40, 8'h20));
        chk("lf_cursor", {23'd0, cursor_x, cursor_y}, {23'd0, 5'd0, 4'd2});
        chk("lf_busy", {31'd0, din_ready}, 32'd0);
        for (int k = 1; k < 20; k++) begin
            tick();
            chk("lf_clear", obs(), wr(40 + k, 8'h20));
        end
        tick();
        chk("lf_ready", {31'd0, din_ready}, 32'd1);
        chk("lf_idle_we", {31'd0, write_en}, 32'd0);

        // Walk down to the last row
        for (int r = 3; r <= 14; r++) begin
            send(8'h0A);
            drain();
        end
        chk("row14", {28'd0, cursor_y}, 32'd14);

        // LF on last row wraps to row 0; a byte held during the clear lands afterwards
        send(8'h0A);
        chk("lf14_first", obs(), wr(0, 8'h20));
        chk("lf14_cursor", {23'd0, cursor_x, cursor_y}, 32'd0);
        din = 8'h5A; din_valid = 1'b1;
        for (int k = 1; k < 20; k++) begin
            tick();
            chk("lf14_clear", obs(), wr(k, 8'h20));
            chk("held_not_taken", {27'd0, cursor_x}, 32'd0);
        end
        tick();
        chk("held_ready", {31'd0, din_ready}, 32'd1);
        chk("held_no_write_yet", {31'd0, write_en}, 32'd0);
        tick();
        din_valid = 1'b0;
        chk("held_write", obs(), wr(0, 8'h5A));
        chk("held_cursor", {27'd0, cursor_x}, 32'd1);

        // Backspace at col 3 then at col 0
        send(8'h62);
        send(8'h63);
        chk("bs_pre_col", {27'd0, cursor_x}, 32'd3);
        send(8'h08);
        chk("bs_write", obs(), wr(2, 8'h20));
        chk("bs_cursor", {27'd0, cursor_x}, 32'd2);
        send(8'h0D);
        send(8'h08);
        chk("bs0_no_write", {31'd0, write_en}, 32'd0);
        chk("bs0_cursor", {23'd0, cursor_x, cursor_y}, 32'd0);

        // Non-printable, non-control bytes are swallowed
        send(8'h63);
        send(8'h07);
        chk("bel_no_write", {31'd0, write_en}, 32'd0);
        chk("bel_cursor", {23'd0, cursor_x, cursor_y}, {23'd0, 5'd1, 4'd0});
        chk("bel_ready", {31'd0, din_ready}, 32'd1);
        send(8'h7F);
        chk("del_no_write", {31'd0, write_en}, 32'd0);
        chk("del_cursor", {23'd0, cursor_x, cursor_y}, {23'd0, 5'd1, 4'd0});

        // Form feed mid-screen, then reset in the middle of the clear
        send(8'h0A);
        drain();
        send(8'h78);
        chk("ff_pre_cursor", {23'd0, cursor_x, cursor_y}, {23'd0, 5'd1, 4'd1});
        send(8'h0C);
        chk("ff_first", obs(), wr(0, 8'h20));
        chk("ff_cursor", {23'd0, cursor_x, cursor_y}, 32'd0);
        chk("ff_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k < 50; k++) begin
            tick();
            chk("ff_clear", obs(), wr(k, 8'h20));
        end
        rstn = 1'b0;
        #1;
        chk("abort_outputs", {14'd0, write_en, waddr, wdata}, 32'd0);
        chk("abort_ready", {31'd0, din_ready}, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        full_clear();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
